commit_unit: RTL and testbench

Retirement back end of the ROB commit interface. It consumes the two-wide in-order commit bundle, updates the architectural rename table (ARAT) and frees old physical registers. It sends one BPU training update per cycle and turns exception, ertn, branch-redirect and privileged-refetch events into a single pipeline flush with a redirect PC. A small FSM blocks further retirement while the front end and back end recover.

---
 rtl/commit_unit_if.sv | 35 +++
 rtl/commit_unit.sv | 153 +++++++++++++++
 tb/tb_commit_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_unit_if.sv
// ROB-to-commit-unit retirement bundle: two in-order slots plus the ready back-pressure.
interface commit_unit_if #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned ARCH_REG_W   = 5,
  parameter int unsigned PHY_REG_W    = 6,
  parameter int unsigned PC_W         = 32
);
  logic [COMMIT_WIDTH-1:0]                 valid;
  logic [COMMIT_WIDTH-1:0][PC_W-1:0]       pc;
  logic [COMMIT_WIDTH-1:0]                 rf_we;
  logic [COMMIT_WIDTH-1:0][ARCH_REG_W-1:0] arch_reg;
  logic [COMMIT_WIDTH-1:0][PHY_REG_W-1:0]  phy_reg;
  logic [COMMIT_WIDTH-1:0][PHY_REG_W-1:0]  old_phy_reg;
  logic [COMMIT_WIDTH-1:0]                 is_br;
  logic [COMMIT_WIDTH-1:0]                 br_taken;
  logic [COMMIT_WIDTH-1:0]                 br_redirect;
  logic [COMMIT_WIDTH-1:0][PC_W-1:0]       br_target;
  logic [COMMIT_WIDTH-1:0]                 excp_valid;
  logic [COMMIT_WIDTH-1:0][5:0]            excp_ecode;
  logic [COMMIT_WIDTH-1:0]                 ertn;
  logic [COMMIT_WIDTH-1:0]                 priv_flush;
  logic                                    ready;

  modport master (
    output valid, pc, rf_we, arch_reg, phy_reg, old_phy_reg, is_br, br_taken,
           br_redirect, br_target, excp_valid, excp_ecode, ertn, priv_flush,
    input  ready
  );

  modport slave (
    input  valid, pc, rf_we, arch_reg, phy_reg, old_phy_reg, is_br, br_taken,
           br_redirect, br_target, excp_valid, excp_ecode, ertn, priv_flush,
    output ready
  );
endinterface

// File: rtl/commit_unit.sv
// Retirement back end: ARAT update, free-list release, BPU training and
// single-flush event handling with a RUN/FLUSH/RECOVER retirement blocker.
module commit_unit #(
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned ARCH_REG_W     = 5,
  parameter int unsigned PHY_REG_W      = 6,
  parameter int unsigned PC_W           = 32,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  commit_unit_if.slave                            cmt,
  input  logic [PC_W-1:0]                         csr_eentry,
  input  logic [PC_W-1:0]                         csr_era,
  output logic [COMMIT_WIDTH-1:0]                 arat_we,
  output logic [COMMIT_WIDTH-1:0][ARCH_REG_W-1:0] arat_idx,
  output logic [COMMIT_WIDTH-1:0][PHY_REG_W-1:0]  arat_phy,
  output logic [COMMIT_WIDTH-1:0]                 fl_release,
  output logic [COMMIT_WIDTH-1:0][PHY_REG_W-1:0]  fl_reg,
  output logic                                    bpu_upd_valid,
  output logic [PC_W-1:0]                         bpu_upd_pc,
  output logic                                    bpu_upd_taken,
  output logic [PC_W-1:0]                         bpu_upd_target,
  output logic                                    flush_o,
  output logic [PC_W-1:0]                         redirect_pc,
  output logic                                    excp_o,
  output logic [5:0]                              excp_ecode_o,
  output logic [PC_W-1:0]                         excp_epc_o,
  output logic [31:0]                             retired_cnt
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        rec_cnt;
  logic                    ready_q;

  logic [COMMIT_WIDTH-1:0] ev;
  logic [COMMIT_WIDTH-1:0] acc;
  logic [COMMIT_WIDTH-1:0] ret;
  logic [COMMIT_WIDTH-1:0] wr;
  logic                    ev_take;
  logic                    ev_slot;
  logic                    ev_excp;
  logic                    bpu_v;
  logic                    bpu_sel;
  logic [1:0]              ret_n;
  logic [PC_W-1:0]         redir_pc;

  assign cmt.ready = ready_q;

  // Slot acceptance, retirement qualification and event selection.
  always_comb begin
    ev       = '0;
    acc      = '0;
    ret      = '0;
    wr       = '0;
    redir_pc = '0;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      ev[i] = cmt.excp_valid[i] | cmt.ertn[i] | cmt.br_redirect[i] | cmt.priv_flush[i];
    end
    acc[0] = ready_q & cmt.valid[0];
    acc[1] = acc[0] & ~ev[0] & cmt.valid[1];
    ret    = acc & ~cmt.excp_valid;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      wr[i] = ret[i] & cmt.rf_we[i] & (cmt.arch_reg[i] != '0);
    end
    ev_take = |(acc & ev);
    ev_slot = ~(acc[0] & ev[0]);
    ev_excp = ev_take & cmt.excp_valid[ev_slot];
    bpu_v   = |(ret & cmt.is_br);
    bpu_sel = ~(ret[0] & cmt.is_br[0]);
    ret_n   = 2'(ret[0]) + 2'(ret[1]);
    // Within the event slot: exception beats ertn beats mispredict beats refetch.
    if (cmt.excp_valid[ev_slot]) begin
      redir_pc = csr_eentry;
    end else if (cmt.ertn[ev_slot]) begin
      redir_pc = csr_era;
    end else if (cmt.br_redirect[ev_slot]) begin
      redir_pc = cmt.br_target[ev_slot];
    end else begin
      redir_pc = cmt.pc[ev_slot] + PC_W'(4);
    end
  end

  // Registered outputs and recovery FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      rec_cnt        <= '0;
      ready_q        <= 1'b1;
      arat_we        <= '0;
      arat_idx       <= '0;
      arat_phy       <= '0;
      fl_release     <= '0;
      fl_reg         <= '0;
      bpu_upd_valid  <= 1'b0;
      bpu_upd_pc     <= '0;
      bpu_upd_taken  <= 1'b0;
      bpu_upd_target <= '0;
      flush_o        <= 1'b0;
      redirect_pc    <= '0;
      excp_o         <= 1'b0;
      excp_ecode_o   <= '0;
      excp_epc_o     <= '0;
      retired_cnt    <= '0;
    end else begin
      arat_we        <= wr;
      arat_idx       <= cmt.arch_reg;
      arat_phy       <= cmt.phy_reg;
      fl_release     <= wr;
      fl_reg         <= cmt.old_phy_reg;
      bpu_upd_valid  <= bpu_v;
      bpu_upd_pc     <= cmt.pc[bpu_sel];
      bpu_upd_taken  <= cmt.br_taken[bpu_sel];
      bpu_upd_target <= cmt.br_target[bpu_sel];
      flush_o        <= ev_take;
      redirect_pc    <= ev_take ? redir_pc : '0;
      excp_o         <= ev_excp;
      excp_ecode_o   <= ev_excp ? cmt.excp_ecode[ev_slot] : '0;
      excp_epc_o     <= ev_excp ? cmt.pc[ev_slot] : '0;
      retired_cnt    <= retired_cnt + 32'(ret_n);

      unique case (state)
        RUN: begin
          if (ev_take) begin
            state   <= FLUSH;
            ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          state   <= RECOVER;
          rec_cnt <= CNT_W'(RECOVER_CYCLES - 1);
        end
        RECOVER: begin
          if (rec_cnt == '0) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            rec_cnt <= rec_cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: slot-walking reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_commit_unit;

  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_unit_if #(.COMMIT_WIDTH(2), .ARCH_REG_W(5), .PHY_REG_W(6), .PC_W(32)) bus ();

  logic [31:0]      csr_eentry, csr_era;
  logic [1:0]       arat_we, fl_release;
  logic [1:0][4:0]  arat_idx;
  logic [1:0][5:0]  arat_phy, fl_reg;
  logic             bpu_upd_valid, bpu_upd_taken, flush_o, excp_o;
  logic [31:0]      bpu_upd_pc, bpu_upd_target, redirect_pc, excp_epc_o, retired_cnt;
  logic [5:0]       excp_ecode_o;

  commit_unit #(
    .COMMIT_WIDTH(2), .ARCH_REG_W(5), .PHY_REG_W(6), .PC_W(32), .RECOVER_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmt(bus),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .arat_we(arat_we), .arat_idx(arat_idx), .arat_phy(arat_phy),
    .fl_release(fl_release), .fl_reg(fl_reg),
    .bpu_upd_valid(bpu_upd_valid), .bpu_upd_pc(bpu_upd_pc),
    .bpu_upd_taken(bpu_upd_taken), .bpu_upd_target(bpu_upd_target),
    .flush_o(flush_o), .redirect_pc(redirect_pc), .excp_o(excp_o),
    .excp_ecode_o(excp_ecode_o), .excp_epc_o(excp_epc_o), .retired_cnt(retired_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state and expected outputs for the next cycle.
  int          cyc;
  int          ready_at;
  logic [1:0]      e_we;
  logic [1:0][4:0] e_idx;
  logic [1:0][5:0] e_phy, e_old;
  logic        e_bv, e_bt, e_flush, e_excp, e_ready;
  logic [31:0] e_bpc, e_btgt, e_redir, e_epc, e_cnt;
  logic [5:0]  e_ecode;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic clear_inputs();
    bus.valid = '0; bus.pc = '0; bus.rf_we = '0; bus.arch_reg = '0;
    bus.phy_reg = '0; bus.old_phy_reg = '0; bus.is_br = '0; bus.br_taken = '0;
    bus.br_redirect = '0; bus.br_target = '0; bus.excp_valid = '0;
    bus.excp_ecode = '0; bus.ertn = '0; bus.priv_flush = '0;
  endtask

  task automatic set_slot(input int s, input logic [31:0] pc, input logic we,
                          input logic [4:0] ar, input logic [5:0] p, input logic [5:0] op);
    bus.valid[s] = 1'b1; bus.pc[s] = pc; bus.rf_we[s] = we;
    bus.arch_reg[s] = ar; bus.phy_reg[s] = p; bus.old_phy_reg[s] = op;
  endtask

  task automatic model_reset();
    cyc = 0; ready_at = 0; e_cnt = '0;
  endtask

  // Walk the slots in program order; the first event ends the bundle.
  task automatic model_eval();
    bit run;
    bit bpu_done;
    int n;
    run = (cyc >= ready_at);
    bpu_done = 0; n = 0;
    e_we = '0; e_bv = 0; e_flush = 0; e_excp = 0;
    for (int s = 0; s < 2; s++) begin
      if (!run || !bus.valid[s]) break;
      if (!bus.excp_valid[s]) begin
        n++;
        if (bus.rf_we[s] && bus.arch_reg[s] != 0) begin
          e_we[s] = 1; e_idx[s] = bus.arch_reg[s];
          e_phy[s] = bus.phy_reg[s]; e_old[s] = bus.old_phy_reg[s];
        end
        if (bus.is_br[s] && !bpu_done) begin
          bpu_done = 1; e_bv = 1; e_bpc = bus.pc[s];
          e_bt = bus.br_taken[s]; e_btgt = bus.br_target[s];
        end
      end
      if (bus.excp_valid[s]) begin
        e_flush = 1; e_redir = csr_eentry; e_excp = 1;
        e_ecode = bus.excp_ecode[s]; e_epc = bus.pc[s];
      end else if (bus.ertn[s]) begin
        e_flush = 1; e_redir = csr_era;
      end else if (bus.br_redirect[s]) begin
        e_flush = 1; e_redir = bus.br_target[s];
      end else if (bus.priv_flush[s]) begin
        e_flush = 1; e_redir = bus.pc[s] + 32'd4;
      end
      if (e_flush) begin
        ready_at = cyc + 2 + RC;
        break;
      end
    end
    e_cnt = e_cnt + 32'(n);
    e_ready = (cyc + 1 >= ready_at);
  endtask

  task automatic compare();
    chk("arat_we", 64'(arat_we), 64'(e_we));
    chk("fl_release", 64'(fl_release), 64'(e_we));
    for (int s = 0; s < 2; s++) begin
      if (e_we[s]) begin
        chk("arat_idx", 64'(arat_idx[s]), 64'(e_idx[s]));
        chk("arat_phy", 64'(arat_phy[s]), 64'(e_phy[s]));
        chk("fl_reg", 64'(fl_reg[s]), 64'(e_old[s]));
      end
    end
    chk("bpu_upd_valid", 64'(bpu_upd_valid), 64'(e_bv));
    if (e_bv) begin
      chk("bpu_upd_pc", 64'(bpu_upd_pc), 64'(e_bpc));
      chk("bpu_upd_taken", 64'(bpu_upd_taken), 64'(e_bt));
      chk("bpu_upd_target", 64'(bpu_upd_target), 64'(e_btgt));
    end
    chk("flush_o", 64'(flush_o), 64'(e_flush));
    if (e_flush) chk("redirect_pc", 64'(redirect_pc), 64'(e_redir));
    chk("excp_o", 64'(excp_o), 64'(e_excp));
    if (e_excp) begin
      chk("excp_ecode_o", 64'(excp_ecode_o), 64'(e_ecode));
      chk("excp_epc_o", 64'(excp_epc_o), 64'(e_epc));
    end
    chk("retired_cnt", 64'(retired_cnt), 64'(e_cnt));
    chk("cmt_ready", 64'(bus.ready), 64'(e_ready));
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    compare();
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arat_we"}, 64'(arat_we), 64'd0);
    chk({tag, "_fl_release"}, 64'(fl_release), 64'd0);
    chk({tag, "_bpu_v"}, 64'(bpu_upd_valid), 64'd0);
    chk({tag, "_flush"}, 64'(flush_o), 64'd0);
    chk({tag, "_redirect"}, 64'(redirect_pc), 64'd0);
    chk({tag, "_excp"}, 64'(excp_o), 64'd0);
    chk({tag, "_cnt"}, 64'(retired_cnt), 64'd0);
  endtask

  int low_cnt;

  initial begin
    clear_inputs();
    csr_eentry = 32'h1C00_8000;
    csr_era    = 32'h1C00_0ABC;
    model_reset();
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(bus.ready), 64'd1);

    // Two plain ALU retirements.
    clear_inputs();
    set_slot(0, 32'h1C00_0000, 1, 5'd3, 6'd10, 6'd4);
    set_slot(1, 32'h1C00_0004, 1, 5'd5, 6'd11, 6'd7);
    step();
    chk("alu_arat_we", 64'(arat_we), 64'b11);
    chk("alu_fl_reg", 64'(fl_reg), 64'({6'd7, 6'd4}));
    chk("alu_cnt", 64'(retired_cnt), 64'd2);
    chk("alu_flush", 64'(flush_o), 64'd0);

    // Exception in slot 0 discards valid slot 1; inputs held during recovery are ignored.
    clear_inputs();
    set_slot(0, 32'h1C00_0100, 1, 5'd8, 6'd12, 6'd13);
    bus.excp_valid[0] = 1'b1; bus.excp_ecode[0] = 6'h0B;
    set_slot(1, 32'h1C00_0104, 1, 5'd6, 6'd20, 6'd21);
    step();
    chk("exc_flush", 64'(flush_o), 64'd1);
    chk("exc_redirect", 64'(redirect_pc), 64'h1C00_8000);
    chk("exc_epc", 64'(excp_epc_o), 64'h1C00_0100);
    chk("exc_ecode", 64'(excp_ecode_o), 64'h0B);
    chk("exc_arat_we", 64'(arat_we), 64'd0);
    chk("exc_cnt", 64'(retired_cnt), 64'd2);
    low_cnt = (bus.ready == 1'b0) ? 1 : 0;
    clear_inputs();
    set_slot(0, 32'h1C00_0110, 1, 5'd9, 6'd30, 6'd31);
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.ready == 1'b0) low_cnt++;
    end
    chk("exc_ready_low_cycles", 64'(low_cnt), 64'd3);
    chk("exc_recover_cnt", 64'(retired_cnt), 64'd2);

    // Mispredicted branch in slot 1: both slots retire, redirect to target.
    clear_inputs();
    set_slot(0, 32'h1C00_01F0, 1, 5'd1, 6'd14, 6'd15);
    set_slot(1, 32'h1C00_0200, 0, 5'd0, 6'd0, 6'd0);
    bus.is_br[1] = 1'b1; bus.br_taken[1] = 1'b1;
    bus.br_redirect[1] = 1'b1; bus.br_target[1] = 32'h1C00_0400;
    step();
    chk("mis_bpu_v", 64'(bpu_upd_valid), 64'd1);
    chk("mis_bpu_pc", 64'(bpu_upd_pc), 64'h1C00_0200);
    chk("mis_redirect", 64'(redirect_pc), 64'h1C00_0400);
    chk("mis_cnt", 64'(retired_cnt), 64'd4);
    chk("mis_excp", 64'(excp_o), 64'd0);
    clear_inputs();
    for (int i = 0; i < 3; i++) step();

    // Two correctly predicted branches: only slot 0 trains the BPU.
    set_slot(0, 32'h1C00_0300, 0, 5'd0, 6'd0, 6'd0);
    bus.is_br[0] = 1'b1; bus.br_taken[0] = 1'b0; bus.br_target[0] = 32'h1C00_0500;
    set_slot(1, 32'h1C00_0304, 0, 5'd0, 6'd0, 6'd0);
    bus.is_br[1] = 1'b1; bus.br_taken[1] = 1'b1; bus.br_target[1] = 32'h1C00_0600;
    step();
    chk("br2_bpu_pc", 64'(bpu_upd_pc), 64'h1C00_0300);
    chk("br2_bpu_taken", 64'(bpu_upd_taken), 64'd0);
    chk("br2_cnt", 64'(retired_cnt), 64'd6);
    chk("br2_flush", 64'(flush_o), 64'd0);

    // Same arch reg in both slots, then ertn in slot 0 discarding slot 1.
    clear_inputs();
    set_slot(0, 32'h1C00_0310, 1, 5'd7, 6'd40, 6'd41);
    set_slot(1, 32'h1C00_0314, 1, 5'd7, 6'd42, 6'd40);
    step();
    chk("dup_arat_phy", 64'(arat_phy), 64'({6'd42, 6'd40}));
    clear_inputs();
    set_slot(0, 32'h1C00_0320, 1, 5'd2, 6'd50, 6'd51);
    bus.ertn[0] = 1'b1;
    set_slot(1, 32'h1C00_0324, 1, 5'd4, 6'd52, 6'd53);
    step();
    chk("ertn_redirect", 64'(redirect_pc), 64'h1C00_0ABC);
    chk("ertn_arat_we", 64'(arat_we), 64'b01);
    chk("ertn_cnt", 64'(retired_cnt), 64'd9);
    clear_inputs();
    for (int i = 0; i < 3; i++) step();

    // Privileged refetch at the top of the address space, writing r0.
    set_slot(0, 32'hFFFF_FFFC, 1, 5'd0, 6'd60, 6'd61);
    bus.priv_flush[0] = 1'b1;
    step();
    chk("priv_flush", 64'(flush_o), 64'd1);
    chk("priv_redirect", 64'(redirect_pc), 64'h0000_0000);
    chk("priv_arat_we", 64'(arat_we), 64'd0);
    chk("priv_fl_release", 64'(fl_release), 64'd0);
    chk("priv_cnt", 64'(retired_cnt), 64'd10);
    clear_inputs();
    step();

    // Asynchronous reset while recovering.
    rst_n = 1'b0;
    #2;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    chk("rst_rel_ready", 64'(bus.ready), 64'd1);
    chk("rst_rel_cnt", 64'(retired_cnt), 64'd0);
    set_slot(0, 32'h1C00_0700, 1, 5'd11, 6'd3, 6'd2);
    step();
    chk("rst_after_cnt", 64'(retired_cnt), 64'd1);
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
